// File: rtl/car_sequencer.sv
// Sensor-side car emulator: drives {outer,inner} through the enter/exit photo-sensor
// pattern with programmable per-phase dwell. Optional back-out support under CARSEQ_ABORT_EN.
module car_sequencer #(
  parameter int DWELL_W = 8,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               dir,
  input  logic [DWELL_W-1:0] dwell,
`ifdef CARSEQ_ABORT_EN
  input  logic               abort,
  output logic               aborted,
`endif
  output logic               outer,
  output logic               inner,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   enter_cnt,
  output logic [CNT_W-1:0]   exit_cnt
);

`ifdef CARSEQ_ABORT_EN
  typedef enum logic [2:0] {IDLE, PH1, PH2, PH3, BACK} state_t;
`else
  typedef enum logic [1:0] {IDLE, PH1, PH2, PH3} state_t;
`endif

  localparam logic [DWELL_W-1:0] DWELL_ONE = DWELL_W'(1);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);

  // {outer,inner} for a given state; BACK replays the first phase as the car reverses out
  function automatic logic [1:0] pattern(input state_t s, input logic d);
    case (s)
      PH1:     pattern = d ? 2'b01 : 2'b10;
      PH2:     pattern = 2'b11;
      PH3:     pattern = d ? 2'b10 : 2'b01;
`ifdef CARSEQ_ABORT_EN
      BACK:    pattern = d ? 2'b01 : 2'b10;
`endif
      default: pattern = 2'b00;
    endcase
  endfunction

  state_t             state_q, state_d;
  logic               dir_q, dir_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0]   enter_cnt_q, enter_cnt_d;
  logic [CNT_W-1:0]   exit_cnt_q, exit_cnt_d;
  logic [1:0]         lines_q, lines_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
`ifdef CARSEQ_ABORT_EN
  logic               aborted_q, aborted_d;
`endif
  logic               expired;

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    dwell_d     = dwell_q;
    cnt_d       = cnt_q;
    enter_cnt_d = enter_cnt_q;
    exit_cnt_d  = exit_cnt_q;
    done_d      = 1'b0;
`ifdef CARSEQ_ABORT_EN
    aborted_d   = 1'b0;
`endif
    expired     = (cnt_q == '0);

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = PH1;
          dir_d   = dir;
          dwell_d = dwell;
          cnt_d   = dwell;
        end
      end
      PH1: begin
`ifdef CARSEQ_ABORT_EN
        if (abort) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
        end else
`endif
        if (expired) begin
          state_d = PH2;
          cnt_d   = dwell_q;
        end else begin
          cnt_d = cnt_q - DWELL_ONE;
        end
      end
      PH2: begin
`ifdef CARSEQ_ABORT_EN
        if (abort) begin
          state_d = BACK;
          cnt_d   = dwell_q;
        end else
`endif
        if (expired) begin
          state_d = PH3;
          cnt_d   = dwell_q;
        end else begin
          cnt_d = cnt_q - DWELL_ONE;
        end
      end
      PH3: begin
        if (expired) begin
          state_d = IDLE;
          done_d  = 1'b1;
          if (dir_q) exit_cnt_d  = exit_cnt_q + CNT_ONE;
          else       enter_cnt_d = enter_cnt_q + CNT_ONE;
        end else begin
          cnt_d = cnt_q - DWELL_ONE;
        end
      end
`ifdef CARSEQ_ABORT_EN
      BACK: begin
        if (expired) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
        end else begin
          cnt_d = cnt_q - DWELL_ONE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    // Lines and busy are registered from the next state so they track it with no input-to-output path
    lines_d = pattern(state_d, dir_d);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      dir_q       <= 1'b0;
      dwell_q     <= '0;
      cnt_q       <= '0;
      enter_cnt_q <= '0;
      exit_cnt_q  <= '0;
      lines_q     <= 2'b00;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef CARSEQ_ABORT_EN
      aborted_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      dwell_q     <= dwell_d;
      cnt_q       <= cnt_d;
      enter_cnt_q <= enter_cnt_d;
      exit_cnt_q  <= exit_cnt_d;
      lines_q     <= lines_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef CARSEQ_ABORT_EN
      aborted_q   <= aborted_d;
`endif
    end
  end

  assign outer     = lines_q[1];
  assign inner     = lines_q[0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign enter_cnt = enter_cnt_q;
  assign exit_cnt  = exit_cnt_q;
`ifdef CARSEQ_ABORT_EN
  assign aborted   = aborted_q;
`endif

endmodule

// File: tb/tb_car_sequencer.sv
// Bench for car_sequencer: timeline model of a car passing the sensors, checked every cycle,
// plus directed sequences with literal expectations.
module tb_car_sequencer;
  localparam int DWELL_W = 8;
  localparam int CNT_W   = 8;
  localparam int CNT_MOD = 1 << CNT_W;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic               dir;
  logic [DWELL_W-1:0] dwell;
  logic               outer, inner, busy, done;
  logic [CNT_W-1:0]   enter_cnt, exit_cnt;
`ifdef CARSEQ_ABORT_EN
  logic               abort;
  logic               aborted;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  car_sequencer #(.DWELL_W(DWELL_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (rst_n),
    .start     (start),
    .dir       (dir),
    .dwell     (dwell),
`ifdef CARSEQ_ABORT_EN
    .abort     (abort),
    .aborted   (aborted),
`endif
    .outer     (outer),
    .inner     (inner),
    .busy      (busy),
    .done      (done),
    .enter_cnt (enter_cnt),
    .exit_cnt  (exit_cnt)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a car is a timeline of 3*(D+1) cycles; t counts cycles spent on it so far
  bit m_active, m_back, m_dir, m_done, m_aborted;
  int m_t, m_d, m_back_left, m_enter, m_exit;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0; m_back = 0; m_dir = 0; m_done = 0; m_aborted = 0;
      m_t = 0; m_d = 0; m_back_left = 0; m_enter = 0; m_exit = 0;
    end else begin
      bit ab;
      int ph;
`ifdef CARSEQ_ABORT_EN
      ab = abort;
`else
      ab = 1'b0;
`endif
      m_done = 0;
      m_aborted = 0;
      if (!m_active) begin
        if (start) begin
          m_active = 1; m_t = 0; m_d = int'(dwell); m_dir = dir;
        end
      end else if (m_back) begin
        if (m_back_left == 0) begin
          m_active = 0; m_back = 0; m_aborted = 1;
        end else begin
          m_back_left--;
        end
      end else begin
        ph = m_t / (m_d + 1);
        if (ab && ph == 0) begin
          m_active = 0; m_aborted = 1;
        end else if (ab && ph == 1) begin
          m_back = 1; m_back_left = m_d;
        end else begin
          m_t++;
          if (m_t == 3 * (m_d + 1)) begin
            m_active = 0; m_done = 1;
            if (m_dir) m_exit = (m_exit + 1) % CNT_MOD;
            else       m_enter = (m_enter + 1) % CNT_MOD;
          end
        end
      end
    end
  end

  function automatic int exp_lines();
    int ph;
    if (!m_active) return 0;
    if (m_back) return m_dir ? 1 : 2;
    ph = m_t / (m_d + 1);
    case (ph)
      0:       return m_dir ? 1 : 2;
      1:       return 3;
      default: return m_dir ? 2 : 1;
    endcase
  endfunction

  always @(negedge clk) begin
    chk("lines", int'({outer, inner}), exp_lines());
    chk("busy", int'(busy), int'(m_active));
    chk("done", int'(done), int'(m_done));
    chk("enter_cnt", int'(enter_cnt), m_enter);
    chk("exit_cnt", int'(exit_cnt), m_exit);
`ifdef CARSEQ_ABORT_EN
    chk("aborted", int'(aborted), int'(m_aborted));
`endif
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, stray;
    logic [1:0] exp_ab [7];
    rst_n = 1'b0; start = 1'b0; dir = 1'b0; dwell = '0;
`ifdef CARSEQ_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_lines", int'({outer, inner}), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_enter", int'(enter_cnt), 0);
    #2 rst_n = 1'b1;

    // Enter, dwell 0
    @(negedge clk); start = 1'b1; dir = 1'b0; dwell = 8'd0;
    @(negedge clk); start = 1'b0; chk("t1_ph1", int'({outer, inner}), 2);
    @(negedge clk); chk("t1_ph2", int'({outer, inner}), 3);
    @(negedge clk); chk("t1_ph3", int'({outer, inner}), 1);
    @(negedge clk);
    chk("t1_idle", int'({outer, inner}), 0);
    chk("t1_done", int'(done), 1);
    chk("t1_enter", int'(enter_cnt), 1);

    // Exit, dwell 3, with ignored start pulses
    @(negedge clk); start = 1'b1; dir = 1'b1; dwell = 8'd3;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      start = (i == 4 || i == 7);
      dir   = 1'b0;
      dwell = 8'd7;
      chk("t2_lines", int'({outer, inner}), (i < 4) ? 1 : (i < 8) ? 3 : 2);
    end
    start = 1'b0;
    @(negedge clk);
    chk("t2_done", int'(done), 1);
    chk("t2_exit", int'(exit_cnt), 1);
    chk("t2_idle", int'({outer, inner}), 0);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      dir   = 1'($urandom);
      dwell = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 31)) : 8'($urandom_range(0, 3));
`ifdef CARSEQ_ABORT_EN
      abort = ($urandom_range(0, 9) == 0);
`endif
    end
    start = 1'b0;
`ifdef CARSEQ_ABORT_EN
    abort = 1'b0;
`endif
    for (int k = 0; k < 200 && busy; k++) @(negedge clk);
    chk("drain_idle", int'(busy), 0);

    // Reset during PH2
    @(negedge clk); start = 1'b1; dir = 1'b0; dwell = 8'd2;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < 20 && {outer, inner} != 2'b11; k++) @(negedge clk);
    chk("rst_reach_ph2", int'({outer, inner}), 3);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_lines", int'({outer, inner}), 0);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_done", int'(done), 0);
    chk("rst_mid_enter", int'(enter_cnt), 0);
    chk("rst_mid_exit", int'(exit_cnt), 0);
    @(negedge clk); #2 rst_n = 1'b1;

    // 256 back-to-back entries with start held high
    @(negedge clk); start = 1'b1; dir = 1'b0; dwell = 8'd0;
    n = 0; stray = 0;
    for (int k = 0; k < 1200 && n < 256; k++) begin
      @(negedge clk);
      if (done) n++;
      else if ({outer, inner} == 2'b00) stray++;
      if (n == 256) start = 1'b0;
    end
    start = 1'b0;
    chk("wrap_count", n, 256);
    chk("wrap_gaps", stray, 0);
    chk("wrap_enter", int'(enter_cnt), 0);

`ifdef CARSEQ_ABORT_EN
    // Abort coinciding with PH2 expiry: back out
    exp_ab = '{2'b10, 2'b10, 2'b11, 2'b11, 2'b10, 2'b10, 2'b00};
    @(negedge clk); start = 1'b1; dir = 1'b0; dwell = 8'd1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      start = 1'b0;
      abort = (i == 3);
      chk("ab2_lines", int'({outer, inner}), int'(exp_ab[i]));
    end
    abort = 1'b0;
    chk("ab2_aborted", int'(aborted), 1);
    chk("ab2_done", int'(done), 0);
    chk("ab2_enter", int'(enter_cnt), 0);

    // Abort in PH3: ignored
    exp_ab = '{2'b10, 2'b10, 2'b11, 2'b11, 2'b01, 2'b01, 2'b00};
    @(negedge clk); start = 1'b1; dir = 1'b0; dwell = 8'd1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      start = 1'b0;
      abort = (i == 4);
      chk("ab3_lines", int'({outer, inner}), int'(exp_ab[i]));
    end
    abort = 1'b0;
    chk("ab3_done", int'(done), 1);
    chk("ab3_aborted", int'(aborted), 0);
    chk("ab3_enter", int'(enter_cnt), 1);
`endif

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/car_sequencer.md
# car_sequencer

Sensor-side driver for the parking-lot gate interface: on command it emits the two photo-sensor lines (`outer`, `inner`) in the exact order a real car produces them when entering or exiting, with programmable dwell per phase. It is the transmitting end of the sensor protocol consumed by the lot's car-detection FSM. It is used for self-test and demo mode, where its outputs are muxed onto the detector inputs in place of the physical sensors. It also keeps wrap-around counts of completed entries and exits.

## Interface
- `DWELL_W`, 8: width of the dwell input and the internal dwell counter.
- `CNT_W`, 8: width of the entry and exit counters.

- `clk`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a car sequence; sampled only when idle.
- `dir`  in  1  0 = enter, 1 = exit; sampled with `start`.
- `dwell`  in  DWELL_W  phase hold length minus one; sampled with `start`.
- `outer`  out  1  emulated outer-sensor blocked (registered).
- `inner`  out  1  emulated inner-sensor blocked (registered).
- `busy`  out  1  high while a sequence is in progress.
- `done`  out  1  one-cycle pulse when a sequence completes.
- `enter_cnt`  out  CNT_W  completed entries; wraps.
- `exit_cnt`  out  CNT_W  completed exits; wraps.
- `abort`  in  1  back-out request; present only with `CARSEQ_ABORT_EN`.
- `aborted`  out  1  one-cycle pulse on back-out completion; present only with `CARSEQ_ABORT_EN`.

## Operation
- States: IDLE, PH1, PH2, PH3, plus BACK with `CARSEQ_ABORT_EN`.
- Patterns `{outer,inner}`:
  - IDLE = 00.
  - Enter: PH1 = 10, PH2 = 11, PH3 = 01.
  - Exit: PH1 = 01, PH2 = 11, PH3 = 10.
  - BACK repeats the PH1 pattern.
- IDLE plus `start` = 1: latch `dir` and `dwell` (value D), load the dwell counter, go to PH1.
- Each phase lasts exactly D+1 cycles (D = 0 gives 1 cycle). The counter reloads on every phase entry.
- Transitions: PH1 → PH2 → PH3 → IDLE.
- On PH3 → IDLE:
  - `done` = 1 for one cycle.
  - Increment `enter_cnt` if dir = 0, otherwise `exit_cnt`.
- Counters wrap from 2^CNT_W−1 to 0.
- `start` while busy: ignored, with no queuing.
- `dir` and `dwell` changes mid-sequence: no effect.

## Timing
- Reset (async, on assertion):
  - `outer` = `inner` = 0, `busy` = 0, `done` = 0, `aborted` = 0.
  - Counters = 0, state = IDLE, latched D = 0.
- Reset mid-sequence drops the lines to 00 immediately. No `done` and no count.
- Start latency: `start` sampled high at edge N puts the PH1 pattern and `busy` = 1 on the outputs from edge N.
- Whole sequence: 3(D+1) cycles of non-00 pattern.
- Completion: `done` = 1, `busy` = 0 and lines = 00 all in the first IDLE cycle. The counter updates at that same edge.
- Back-to-back: `start` high during the `done` cycle is accepted. There is exactly one 00 cycle between sequences.
- Outputs are registered: no combinational path from any input to `outer` or `inner`.

## Configuration
- `CARSEQ_ABORT_EN` defined: `abort` and `aborted` ports exist.
  - `abort` = 1 sampled in PH1: next state IDLE, `aborted` pulse in that IDLE cycle.
  - `abort` = 1 sampled in PH2: next state BACK, held D+1 cycles, then IDLE with `aborted` pulse.
  - `abort` is ignored in PH3, BACK and IDLE.
  - An aborted sequence never pulses `done` and never increments a counter.
  - `abort` and phase expiry on the same edge: abort wins.
- `CARSEQ_ABORT_EN` undefined: no abort ports, no BACK state, all sequences run to completion.

## Test plan
- Reset low, release; `start` = 1, dir = 0, dwell = 0 → lines 10, 11, 01 (1 cycle each), then 00 with `done` = 1 and `enter_cnt` = 1; detector enter pulse on the 00 cycle.
- dir = 1, dwell = 3 → lines 01 ×4, 11 ×4, 10 ×4, then `done`; `exit_cnt` = 1; `start` pulses while busy are ignored.
- Start asserted in the `done` cycle, repeated 256 times with CNT_W = 8 → exactly one 00 cycle between sequences; `enter_cnt` wraps to 0.
- Reset low during PH2 (lines 11) → lines 00 immediately (before next edge), counters 0, no `done`.
- With `CARSEQ_ABORT_EN`, dir = 0, dwell = 1, `abort` in PH2 → 10 ×2, 11 ×2, 10 ×2, 00 with `aborted` = 1, `done` = 0, counts unchanged; same `abort` in PH3 → ignored, normal `done`.
